// File: rtl/fetch_ir_stage_pkg.sv
// Shared definitions for the fetch / instruction-register stage of the
// 16-bit processor: field positions, PC step, FSM state encoding and the
// sequential PC increment helper.
package fetch_ir_stage_pkg;

    localparam int          INSTR_W    = 16;
    localparam logic [15:0] PC_STEP    = 16'd2;

    // Instruction field positions inside the IR.
    localparam int          OPCODE_MSB = 15;
    localparam int          OPCODE_LSB = 12;
    localparam int          IMM8_MSB   = 7;
    localparam int          IMM8_LSB   = 0;

    // Fetch FSM: IDLE has no request outstanding, WAIT holds one request.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    // Next sequential PC; wraps modulo 2^16 so 16'hFFFE steps to 16'h0000.
    function automatic logic [15:0] pc_next_seq(input logic [15:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_ir_stage_if.sv
// Bus bundle of the fetch stage.
//   Memory side : mem_req/mem_addr out, mem_ack/mem_rdata in (one outstanding read).
//   Decode side : ir_valid/ir/ir_pc/opcode/imm8 out, ir_ready in (valid/ready),
//                 redirect_valid/redirect_offset in (taken branch for the IR).
// The master modport is the fetch stage itself; slave is its environment.
interface fetch_ir_stage_if;
    import fetch_ir_stage_pkg::*;

    logic                 mem_req;
    logic [15:0]          mem_addr;
    logic                 mem_ack;
    logic [INSTR_W-1:0]   mem_rdata;

    logic                 ir_valid;
    logic                 ir_ready;
    logic [INSTR_W-1:0]   ir;
    logic [15:0]          ir_pc;
    logic [3:0]           opcode;
    logic [7:0]           imm8;

    logic                 redirect_valid;
    logic [15:0]          redirect_offset;

    modport master (
        output mem_req, mem_addr, ir_valid, ir, ir_pc, opcode, imm8,
        input  mem_ack, mem_rdata, ir_ready, redirect_valid, redirect_offset
    );

    modport slave (
        input  mem_req, mem_addr, ir_valid, ir, ir_pc, opcode, imm8,
        output mem_ack, mem_rdata, ir_ready, redirect_valid, redirect_offset
    );

endinterface

// File: rtl/fetch_ir_stage_br_target.sv
// Branch target adder for the fetch stage.
//   ir_pc  : byte address of the branching instruction
//   offset : signed word offset from se_8b_16b
//   target : ir_pc + 2 + offset*2, wrapping modulo 2^16 (carry discarded)
module fetch_ir_stage_br_target
    import fetch_ir_stage_pkg::*;
(
    input  logic [15:0] ir_pc,
    input  logic [15:0] offset,
    output logic [15:0] target
);

    // Word offset to byte offset: the dropped MSB only matters above 2^16,
    // where the sum wraps anyway, so bit 0 of the target follows ir_pc (0).
    assign target = ir_pc + PC_STEP + {offset[14:0], 1'b0};

endmodule

// File: rtl/fetch_ir_stage.sv
// Instruction fetch and IR stage.
//   clk, reset_n : single clock, synchronous active-low reset
//   bus (master) : instruction-memory request/ack with one outstanding read,
//                  IR valid/ready handshake with opcode/imm8 slices, and the
//                  branch redirect (taken only when the IR is consumed).
// Holds PC, IR, IR's PC and a two-state fetch FSM.
module fetch_ir_stage #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int          INSTR_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    fetch_ir_stage_if.master bus
);
    import fetch_ir_stage_pkg::*;

    fetch_state_e        state_r;
    fetch_state_e        state_n_s;
    logic [15:0]         pc_r;
    logic [15:0]         pc_n_s;
    logic [INSTR_W-1:0]  ir_r;
    logic [INSTR_W-1:0]  ir_n_s;
    logic [15:0]         ir_pc_r;
    logic [15:0]         ir_pc_n_s;
    logic                ir_valid_r;
    logic                ir_valid_n_s;
    logic                mem_req_r;
    logic                mem_req_n_s;
    logic                consume_s;
    logic [15:0]         target_s;

    fetch_ir_stage_br_target u_br_target (
        .ir_pc  (ir_pc_r),
        .offset (bus.redirect_offset),
        .target (target_s)
    );

    assign consume_s = ir_valid_r & bus.ir_ready;

    // Next-state and next-register logic of the fetch FSM.
    always_comb begin
        state_n_s    = state_r;
        pc_n_s       = pc_r;
        ir_n_s       = ir_r;
        ir_pc_n_s    = ir_pc_r;
        ir_valid_n_s = ir_valid_r;
        mem_req_n_s  = mem_req_r;
        case (state_r)
            IDLE: begin
                if (consume_s && bus.redirect_valid) begin
                    // Taken branch: retarget and fetch from it next cycle.
                    pc_n_s       = target_s;
                    ir_valid_n_s = 1'b0;
                    mem_req_n_s  = 1'b0;
                end else if (!ir_valid_r || consume_s) begin
                    // IR empty or draining: no ack can land in IDLE, so it empties.
                    mem_req_n_s  = 1'b1;
                    ir_valid_n_s = 1'b0;
                    state_n_s    = WAIT;
                end else begin
                    // Stalled: redirect without consume is ignored.
                    mem_req_n_s  = 1'b0;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    ir_n_s       = bus.mem_rdata;
                    ir_pc_n_s    = pc_r;
                    pc_n_s       = pc_next_seq(pc_r);
                    ir_valid_n_s = 1'b1;
                    mem_req_n_s  = 1'b0;
                    state_n_s    = IDLE;
                end else begin
                    // Address and request held stable until the ack.
                    mem_req_n_s  = 1'b1;
                end
            end
            default: begin
                state_n_s    = IDLE;
                mem_req_n_s  = 1'b0;
                ir_valid_n_s = 1'b0;
            end
        endcase
    end

    // State registers; a reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            pc_r       <= PC_RESET;
            ir_r       <= {INSTR_W{1'b0}};
            ir_pc_r    <= 16'h0000;
            ir_valid_r <= 1'b0;
            mem_req_r  <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            pc_r       <= pc_n_s;
            ir_r       <= ir_n_s;
            ir_pc_r    <= ir_pc_n_s;
            ir_valid_r <= ir_valid_n_s;
            mem_req_r  <= mem_req_n_s;
        end
    end

    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = pc_r;
    assign bus.ir_valid = ir_valid_r;
    assign bus.ir       = ir_r;
    assign bus.ir_pc    = ir_pc_r;
    assign bus.opcode   = ir_r[OPCODE_MSB:OPCODE_LSB];
    assign bus.imm8     = ir_r[IMM8_MSB:IMM8_LSB];

endmodule

// File: tb/tb_fetch_ir_stage.sv
// Bench for fetch_ir_stage: directed scenarios with literal expectations,
// then randomized traffic checked each cycle against a behavioural model.
module tb_fetch_ir_stage;

    logic clk;
    logic reset_n;
    logic reset2_n;

    int n_total;
    int n_pass;

    fetch_ir_stage_if bus ();
    fetch_ir_stage_if bus2 ();

    fetch_ir_stage #(.PC_RESET(16'h0000), .INSTR_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    fetch_ir_stage #(.PC_RESET(16'hFFFE), .INSTR_W(16)) dut_wrap (
        .clk     (clk),
        .reset_n (reset2_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model of the stage attached to dut.
    logic        m_known;
    logic        m_busy;
    logic [15:0] m_pc;
    logic        m_irv;
    logic [15:0] m_ir;
    logic [15:0] m_irpc;

    function automatic logic [15:0] model_target(input logic [15:0] pc, input logic [15:0] off);
        int t;
        t = int'(pc) + 2 + 2 * int'($signed(off));
        return t[15:0];
    endfunction

    initial m_known = 1'b0;

    // Model update on every rising edge from the inputs held during the cycle.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_known <= 1'b1;
            m_busy  <= 1'b0;
            m_pc    <= 16'h0000;
            m_irv   <= 1'b0;
            m_ir    <= 16'h0000;
            m_irpc  <= 16'h0000;
        end else if (m_busy) begin
            if (bus.mem_ack) begin
                m_ir   <= bus.mem_rdata;
                m_irpc <= m_pc;
                m_pc   <= 16'((int'(m_pc) + 2) % 65536);
                m_irv  <= 1'b1;
                m_busy <= 1'b0;
            end
        end else if (m_irv && bus.ir_ready && bus.redirect_valid) begin
            m_pc  <= model_target(m_irpc, bus.redirect_offset);
            m_irv <= 1'b0;
        end else if (!m_irv || bus.ir_ready) begin
            m_busy <= 1'b1;
            m_irv  <= 1'b0;
        end
    end

    // Compare dut against the model mid-cycle.
    always @(negedge clk) begin
        if (m_known) begin
            check("mem_req",  32'(bus.mem_req),  32'(m_busy));
            check("mem_addr", 32'(bus.mem_addr), 32'(m_pc));
            check("ir_valid", 32'(bus.ir_valid), 32'(m_irv));
            check("ir",       32'(bus.ir),       32'(m_ir));
            check("ir_pc",    32'(bus.ir_pc),    32'(m_irpc));
            check("opcode",   32'(bus.opcode),   32'(m_ir >> 12));
            check("imm8",     32'(bus.imm8),     32'(m_ir & 16'h00FF));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset_n  = 1'b0;
        reset2_n = 1'b0;
        bus.mem_ack = 1'b0;          bus.mem_rdata = 16'h0000;
        bus.ir_ready = 1'b0;         bus.redirect_valid = 1'b0;
        bus.redirect_offset = 16'h0000;
        bus2.mem_ack = 1'b0;         bus2.mem_rdata = 16'h0000;
        bus2.ir_ready = 1'b0;        bus2.redirect_valid = 1'b0;
        bus2.redirect_offset = 16'h0000;

        // Reset and first fetch.
        step(); step();
        check("rst_mem_req",  32'(bus.mem_req),  32'h0);
        check("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0000);
        reset_n = 1'b1;
        step();
        check("first_req",  32'(bus.mem_req),  32'h1);
        check("first_addr", 32'(bus.mem_addr), 32'h0000);

        // Same-cycle ack of 16'h1234.
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
        step();
        bus.mem_ack = 1'b0;
        check("fetch_ir",     32'(bus.ir),       32'h1234);
        check("fetch_ir_pc",  32'(bus.ir_pc),    32'h0000);
        check("fetch_opcode", 32'(bus.opcode),   32'h1);
        check("fetch_imm8",   32'(bus.imm8),     32'h34);
        check("fetch_valid",  32'(bus.ir_valid), 32'h1);
        check("fetch_next",   32'(bus.mem_addr), 32'h0002);

        // Stall with a redirect pulse that must be ignored.
        for (int i = 0; i < 5; i++) begin
            bus.redirect_valid = (i == 2);
            bus.redirect_offset = 16'h0040;
            step();
            check("stall_req",  32'(bus.mem_req),  32'h0);
            check("stall_ir",   32'(bus.ir),       32'h1234);
            check("stall_addr", 32'(bus.mem_addr), 32'h0002);
        end

        // Forward branch from ir_pc 0: 0 + 2 + 7*2 = 0x0010.
        bus.ir_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_offset = 16'h0007;
        step();
        check("br_fwd_addr",  32'(bus.mem_addr), 32'h0010);
        check("br_fwd_valid", 32'(bus.ir_valid), 32'h0);
        check("br_fwd_noreq", 32'(bus.mem_req),  32'h0);
        bus.redirect_valid = 1'b0; bus.ir_ready = 1'b0;
        step();
        check("br_fwd_req", 32'(bus.mem_req), 32'h1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'hA5C3;
        step();
        bus.mem_ack = 1'b0;
        check("ir_pc_10",  32'(bus.ir_pc),  32'h0010);
        check("opcode_a",  32'(bus.opcode), 32'hA);
        check("imm8_c3",   32'(bus.imm8),   32'hC3);

        // Backward branch: 0x10 + 2 - 16 = 0x0002.
        bus.ir_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_offset = 16'hFFF8;
        step();
        check("br_back_addr",  32'(bus.mem_addr), 32'h0002);
        check("br_back_valid", 32'(bus.ir_valid), 32'h0);
        bus.redirect_valid = 1'b0; bus.ir_ready = 1'b0;
        step();
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7001;
        step();
        bus.mem_ack = 1'b0;

        // From ir_pc 2 to 0xFFF0, then a wrapping branch to 0x0012.
        bus.ir_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_offset = 16'h7FF6;
        step();
        check("br_fff0", 32'(bus.mem_addr), 32'hFFF0);
        bus.redirect_valid = 1'b0; bus.ir_ready = 1'b0;
        step();
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'h3C00;
        step();
        bus.mem_ack = 1'b0;
        check("ir_pc_fff0", 32'(bus.ir_pc), 32'hFFF0);
        bus.ir_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_offset = 16'h0010;
        step();
        check("br_wrap", 32'(bus.mem_addr), 32'h0012);
        bus.redirect_valid = 1'b0; bus.ir_ready = 1'b0;
        step();
        check("wait_req", 32'(bus.mem_req), 32'h1);

        // Reset while waiting, with an ack in the same cycle.
        reset_n = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
        step();
        check("rstw_valid", 32'(bus.ir_valid), 32'h0);
        check("rstw_ir",    32'(bus.ir),       32'h0000);
        check("rstw_addr",  32'(bus.mem_addr), 32'h0000);
        check("rstw_req",   32'(bus.mem_req),  32'h0);
        reset_n = 1'b1; bus.mem_ack = 1'b0;

        // Randomized traffic, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset_n             = ($urandom_range(0, 99) != 0);
            bus.mem_ack         = ($urandom_range(0, 2) != 0);
            bus.mem_rdata       = 16'($urandom);
            bus.ir_ready        = 1'($urandom_range(0, 1));
            bus.redirect_valid  = ($urandom_range(0, 3) == 0);
            bus.redirect_offset = 16'($urandom);
            step();
        end

        // Sequential PC wrap on the instance reset to 0xFFFE.
        check("wrap_rst_addr", 32'(bus2.mem_addr), 32'hFFFE);
        reset2_n = 1'b1;
        step();
        check("wrap_req",  32'(bus2.mem_req),  32'h1);
        check("wrap_addr", 32'(bus2.mem_addr), 32'hFFFE);
        bus2.mem_ack = 1'b1; bus2.mem_rdata = 16'h2468;
        step();
        bus2.mem_ack = 1'b0;
        check("wrap_ir_pc", 32'(bus2.ir_pc),    32'hFFFE);
        check("wrap_next",  32'(bus2.mem_addr), 32'h0000);
        bus2.ir_ready = 1'b1;
        step();
        check("wrap_req2",  32'(bus2.mem_req),  32'h1);
        check("wrap_addr2", 32'(bus2.mem_addr), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
